// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one sync_fifo write port
// Registered grant per burst; data and handshakes are steered combinationally from the owner.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 8,
  parameter int WR_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic [$clog2(WR_DEPTH):0]     fifo_wr_data_space,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [IDW-1:0]  last_id;
  logic [CW-1:0]   beat_cnt;

  logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign req_slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from last_id+1 upward; iterating downward lets the nearest candidate win.
  logic               win_found;
  logic [IDW-1:0]     win_id;
  logic [IDW-1:0]     cand;
  logic [NUM_REQ-1:0] win_onehot;
  always_comb begin
    win_found  = 1'b0;
    win_id     = '0;
    cand       = '0;
    win_onehot = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDW'((int'(last_id) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
    win_onehot[win_id] = 1'b1;
  end

  logic in_burst;
  logic xfer;
  logic burst_end;

  assign in_burst   = (state == BURST);
  assign xfer       = in_burst & req_valid[grant_id] & ~fifo_full;
  assign burst_end  = xfer & (req_last[grant_id] | (beat_cnt == CW'(MAX_BURST - 1)));
  assign req_ready  = (in_burst & ~fifo_full) ? grant : '0;
  assign fifo_wr_en = xfer;
  assign fifo_din   = in_burst ? req_slice[grant_id] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      last_id  <= IDW'(NUM_REQ - 1);
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found && (fifo_wr_data_space != '0)) begin
            state    <= BURST;
            grant    <= win_onehot;
            grant_id <= win_id;
            beat_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        BURST: begin
          if (burst_end) begin
            state    <= IDLE;
            grant    <= '0;
            last_id  <= grant_id;
            beat_cnt <= '0;
            busy     <= 1'b0;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed scoreboard bench for fifo_wr_arbiter
// Requester queues feed the DUT; expected FIFO writes are queued ahead and matched on wr_en.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int MB   = 8;
  localparam int WD   = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full;
  logic [4:0]        fifo_wr_data_space;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_din;
  logic [NREQ-1:0]   grant;
  logic [1:0]        grant_id;
  logic              busy;

  fifo_wr_arbiter #(
    .NUM_REQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MB), .WR_DEPTH(WD)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr_data_space(fifo_wr_data_space),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .grant(grant), .grant_id(grant_id), .busy(busy)
  );

  always #5 clock = ~clock;

  int            tests = 0;
  int            fails = 0;
  logic [64:0]   src_q [NREQ][$];
  logic [63:0]   exp_q [$];
  int            order_q [$];
  logic [NREQ-1:0] hs = '0;
  logic          prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic bit src_empty();
    bit e = 1'b1;
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() != 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = src_q[i][0][63:0];
        req_last[i]          = src_q[i][0][64];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic push_src(input int id, input logic [63:0] d, input logic l);
    src_q[id].push_back({l, d});
  endtask

  task automatic sample_edge();
    @(negedge clock);
    if (fifo_wr_en === 1'b1) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("sb_din", fifo_din, exp_q.pop_front());
    end
    if (busy === 1'b1 && prev_busy == 1'b0) order_q.push_back(int'(grant_id));
    prev_busy = busy;
    hs = req_valid & req_ready;
  endtask

  task automatic clock_edge();
    @(posedge clock);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    hs = '0;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fifo_full = 1'b0;
    fifo_wr_data_space = 5'd16;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    hs = '0;
    drive();
    clock_edge();
    clock_edge();
    reset = 1'b0;
    order_q.delete();
    prev_busy = 1'b0;
  endtask

  task automatic run_until(input string tag, input int max_cyc, output int used);
    bit done = 1'b0;
    used = 0;
    for (int c = 1; c <= max_cyc && !done; c++) begin
      sample_edge();
      clock_edge();
      if (exp_q.size() == 0 && src_empty()) begin
        done = 1'b1;
        used = c;
      end
    end
    chk({tag, "_drained"}, 64'(done), 64'd1);
  endtask

  task automatic check_order(input string tag, input int eo[$]);
    chk({tag, "_order_len"}, 64'(order_q.size()), 64'(eo.size()));
    for (int k = 0; k < eo.size() && k < order_q.size(); k++)
      chk({tag, "_order"}, 64'(order_q[k]), 64'(eo[k]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int cyc;
    int eo [$];

    // reset state
    req_valid = '0; req_data = '0; req_last = '0;
    do_reset();
    sample_edge();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_din", fifo_din, 64'd0);
    clock_edge();

    // single requester, 3-beat burst
    do_reset();
    push_src(2, 64'hA0, 1'b0); push_src(2, 64'hA1, 1'b0); push_src(2, 64'hA2, 1'b1);
    exp_q.push_back(64'hA0); exp_q.push_back(64'hA1); exp_q.push_back(64'hA2);
    drive();
    sample_edge();
    chk("t1_grant_pre", 64'(grant), 64'd0);
    clock_edge();
    sample_edge();
    chk("t1_grant", 64'(grant), 64'h4);
    chk("t1_busy", 64'(busy), 64'd1);
    clock_edge();
    sample_edge();
    clock_edge();
    sample_edge();
    chk("t1_busy_mid", 64'(busy), 64'd1);
    clock_edge();
    sample_edge();
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_grant_end", 64'(grant), 64'd0);
    chk("t1_grant_id", 64'(grant_id), 64'd2);
    chk("t1_wr_en_end", 64'(fifo_wr_en), 64'd0);
    chk("t1_exp_left", 64'(exp_q.size()), 64'd0);
    clock_edge();

    // round robin, four requesters with 2-beat bursts
    do_reset();
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 2; k++) begin
        push_src(b % NREQ, 64'hB000 + 64'(b * 16 + k), k == 1);
        exp_q.push_back(64'hB000 + 64'(b * 16 + k));
      end
    drive();
    run_until("rr", 40, cyc);
    chk("rr_cycles", 64'(cyc), 64'd15);
    eo = '{0, 1, 2, 3, 0};
    check_order("rr", eo);

    // MAX_BURST cut-off with a competing requester
    do_reset();
    for (int k = 0; k < 20; k++) push_src(1, 64'hC00 + 64'(k), 1'b0);
    push_src(3, 64'hD0, 1'b0); push_src(3, 64'hD1, 1'b1);
    for (int k = 0; k < 8; k++) exp_q.push_back(64'hC00 + 64'(k));
    exp_q.push_back(64'hD0); exp_q.push_back(64'hD1);
    for (int k = 8; k < 20; k++) exp_q.push_back(64'hC00 + 64'(k));
    drive();
    run_until("mb", 80, cyc);
    eo = '{1, 3, 1, 1};
    check_order("mb", eo);

    // back-pressure during beat 2 of a 4-beat burst
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_src(0, 64'hE0 + 64'(k), k == 3);
      exp_q.push_back(64'hE0 + 64'(k));
    end
    drive();
    for (int k = 0; k < 3; k++) begin
      sample_edge();
      clock_edge();
    end
    fifo_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample_edge();
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_wr_en", 64'(fifo_wr_en), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      clock_edge();
    end
    fifo_full = 1'b0;
    run_until("bp", 10, cyc);
    sample_edge();
    chk("bp_busy_end", 64'(busy), 64'd0);
    clock_edge();

    // zero write space holds off the grant
    do_reset();
    fifo_wr_data_space = 5'd0;
    push_src(0, 64'hF0, 1'b1);
    exp_q.push_back(64'hF0);
    drive();
    for (int k = 0; k < 3; k++) begin
      sample_edge();
      chk("zs_grant_held", 64'(grant), 64'd0);
      clock_edge();
    end
    fifo_wr_data_space = 5'd1;
    sample_edge();
    chk("zs_grant_pre", 64'(grant), 64'd0);
    clock_edge();
    sample_edge();
    chk("zs_grant", 64'(grant), 64'h1);
    clock_edge();
    run_until("zs", 10, cyc);
    eo = '{0};
    check_order("zs", eo);

    // reset during beat 3 of 6, then the pointer restarts at requester 0
    do_reset();
    for (int k = 0; k < 6; k++) push_src(2, 64'h2000 + 64'(k), k == 5);
    for (int k = 0; k < 3; k++) exp_q.push_back(64'h2000 + 64'(k));
    drive();
    for (int k = 0; k < 3; k++) begin
      sample_edge();
      clock_edge();
    end
    reset = 1'b1;
    sample_edge();
    chk("mr_wr_en_in_reset", 64'(fifo_wr_en), 64'd1);
    clock_edge();
    reset = 1'b0;
    src_q[2].delete();
    drive();
    sample_edge();
    chk("mr_grant", 64'(grant), 64'd0);
    chk("mr_grant_id", 64'(grant_id), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_ready", 64'(req_ready), 64'd0);
    chk("mr_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("mr_din", fifo_din, 64'd0);
    chk("mr_exp_left", 64'(exp_q.size()), 64'd0);
    clock_edge();
    order_q.delete();
    push_src(3, 64'h3000, 1'b1);
    push_src(0, 64'h1000, 1'b1);
    exp_q.push_back(64'h1000);
    exp_q.push_back(64'h3000);
    drive();
    run_until("mr", 10, cyc);
    eo = '{0, 3};
    check_order("mr", eo);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `sync_fifo` write port among `NUM_REQ` producers. Each producer presents a valid/ready/last beat stream. The arbiter grants one producer at a time for a burst, then steers that producer's data onto the FIFO's `wr_en`/`din`. It sits directly in front of the FIFO and honours the FIFO's `full` and `wr_data_space` outputs.

## Interface
**Parameters**
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 64: beat width; equals the FIFO `INPUT_WIDTH`.
- `MAX_BURST`, 8: maximum beats per grant, ≥1.
- `WR_DEPTH`, 16: FIFO write depth; sizes `fifo_wr_data_space`.

**Ports**
- `clock`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  marks the final beat of a requester's burst.
- `req_ready`  out  NUM_REQ  per-requester beat accept.
- `fifo_full`  in  1  from the FIFO `full` output.
- `fifo_wr_data_space`  in  $clog2(WR_DEPTH)+1  from the FIFO `wr_data_space` output.
- `fifo_wr_en`  out  1  to the FIFO `wr_en` input.
- `fifo_din`  out  DATA_WIDTH  to the FIFO `din` input.
- `grant`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or most recent owner.
- `busy`  out  1  high while in BURST.

## Operation
- **FSM states:** IDLE and BURST.
- **Reset values:** state IDLE; `grant` 0; `grant_id` 0; round-robin pointer `last_id` = NUM_REQ-1, so requester 0 wins first; beat counter 0; `busy` 0. The combinational outputs `req_ready`, `fifo_wr_en` and `fifo_din` are all 0 while state is IDLE.
- **IDLE → BURST:** taken when `req_valid` is non-zero and `fifo_wr_data_space` is not 0. The winner is the first asserted requester scanning `last_id+1, last_id+2, …` modulo NUM_REQ. The arbiter registers `grant`/`grant_id` and clears the beat counter.
- **IDLE with `fifo_wr_data_space` = 0:** no grant is issued.
- **BURST, write condition:** `xfer = req_valid[g] & ~fifo_full`.
  - `req_ready[g] = ~fifo_full`.
  - `req_ready` is 0 for every non-granted requester.
  - `fifo_wr_en = xfer`.
  - `fifo_din = req_data` slice g.
- **Beat counter:** increments on each `xfer`.
- **Burst end:** an `xfer` with `req_last[g]` set, or an `xfer` where beat counter = MAX_BURST-1.
  - On burst end: next state IDLE, `last_id <= g`, `grant` cleared at the edge. `grant_id` holds its value.
- **`req_valid[g]` low mid-burst:** no transfer that cycle; the grant is held with no timeout.
- **`fifo_full` high in BURST:** no transfer; the grant and beat counter hold.
- **Non-granted requesters:** their `req_valid`/`req_last` are ignored and they must hold their data.
- **Reset asserted mid-burst:** returns to reset values at the next edge, and the in-flight burst is abandoned.
  - `fifo_wr_en` is 0 in the cycle after reset is sampled.
  - If `reset` is high in the same cycle as an `xfer`, the FIFO still sees that `wr_en`. The FIFO is reset by the same signal, so the beat is discarded.

## Timing
- **Grant latency:** `req_valid` sampled high in IDLE at edge N makes `grant` visible after edge N. The first FIFO write is accepted at edge N+1.
- **Burst gap:** there is one mandatory IDLE cycle between consecutive bursts. Sustained throughput is therefore B/(B+1) beats per cycle for burst length B.
- **Combinational paths:** `fifo_full` → `req_ready`/`fifo_wr_en` is combinational, with no register stage. `req_valid[g]` → `fifo_wr_en` is combinational.
- **`fifo_wr_data_space` usage:** sampled only in IDLE. Overflow protection within a burst relies on `fifo_full`.
- **Simultaneous requests:** a new request arriving in the same cycle a burst ends is considered in the following IDLE cycle. The requester that just finished has the lowest priority there.

## Test plan
- **Single requester:** reset, then requester 2 sends 3 beats (0xA0, 0xA1, 0xA2; last on the third) → `grant` = 4'b0100 one cycle after valid; FIFO receives exactly those 3 beats on 3 consecutive edges; `busy` falls after the third; `grant_id` stays 2.
- **Round-robin order:** all four requesters hold valid with 2-beat bursts after reset → grant order 0,1,2,3,0; one idle cycle between bursts; 5 bursts take 15 cycles.
- **MAX_BURST cut-off:** requester 1 streams 20 beats with no last, MAX_BURST = 8 → 8 beats are written and the arbiter returns to IDLE. Requester 3 is also valid, so it is granted next, then requester 1 resumes with beat 9.
- **Back-pressure:** `fifo_full` is forced high for 4 cycles during beat 2 of a 4-beat burst → `req_ready` and `fifo_wr_en` are 0 for those 4 cycles; no beat is lost or duplicated; the beat counter resumes at 2.
- **Zero space:** `fifo_wr_data_space` = 0 with requester 0 valid → `grant` stays 0 until space becomes 1, then grant follows one cycle later.
- **Reset mid-burst:** `reset` is asserted during beat 3 of 6 → all outputs are 0 next cycle. After `reset` is released, a fresh request from requester 3 with requester 0 also valid → requester 0 wins (pointer reset).
